// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Three-state instruction fetch unit. It issues one word read to instruction
// memory, waits as long as needed for the data, latches the word into the
// instruction register and holds it until the back end consumes it. A branch
// redirect can arrive in any state. It discards any in-flight data and restarts
// fetching at the branch target.
//
// Ports
//   CLOCK_50            in   system clock (all registers use the rising edge)
//   RESET_N             in   synchronous active-low reset
//   IMEM_req            out  instruction-memory read request
//   IMEM_addr[15:0]     out  word address being fetched (current PC)
//   IMEM_ready          in   IMEM_data valid this cycle (only while IMEM_req=1)
//   IMEM_data[31:0]     in   instruction word from memory
//   stall               in   back end cannot consume the current instruction
//   branch_taken        in   single-cycle redirect pulse
//   branch_target[15:0] in   redirect word address
//   IR_valid            out  IR holds an unconsumed instruction
//   IR_opcode[3:0]      out  IR[31:28]
//   IR_ARn/ARs/ARm[3:0] out  IR[23:20], IR[19:16], IR[15:12]
//   IR_imm[15:0]        out  IR[15:0]
//   mux_ARd_or_15[3:0]  out  register-file write address (R15 for branch-and-link)
//   CNTRL_write_en_ARd  out  register-file write enable, one pulse per consumed writer
//   PC_next[15:0]       out  address of the instruction in IR, plus 1
// -----------------------------------------------------------------------------
module instr_fetch (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    output logic        IMEM_req,
    output logic [15:0] IMEM_addr,
    input  logic        IMEM_ready,
    input  logic [31:0] IMEM_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        IR_valid,
    output logic [3:0]  IR_opcode,
    output logic [3:0]  IR_ARn,
    output logic [3:0]  IR_ARs,
    output logic [3:0]  IR_ARm,
    output logic [15:0] IR_imm,
    output logic [3:0]  mux_ARd_or_15,
    output logic        CNTRL_write_en_ARd,
    output logic [15:0] PC_next
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic [31:0] ir;
    logic        ir_valid;
    logic [15:0] pc_next_r;

    logic        mem_req;
    logic        load_ir;
    logic        consume;
    logic        writes_reg;

    assign pc_inc = pc + 16'd1;

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control strobes. A redirect overrides everything the
    // case statement decided, so data returning in the same cycle is dropped.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        load_ir   = 1'b0;
        consume   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                mem_req = 1'b1;
                if (IMEM_ready) begin
                    load_ir   = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ir_valid && !stall) begin
                    consume   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
        if (branch_taken) begin
            load_ir   = 1'b0;
            consume   = 1'b0;
            state_nxt = S_FETCH;
        end
    end

    // PC, instruction register and its valid flag. IR and PC_next keep their
    // old contents across a redirect; only IR_valid is cleared.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            pc        <= 16'h0000;
            ir        <= 32'h0000_0000;
            ir_valid  <= 1'b0;
            pc_next_r <= 16'h0000;
        end else if (branch_taken) begin
            pc       <= branch_target;
            ir_valid <= 1'b0;
        end else if (load_ir) begin
            ir        <= IMEM_data;
            ir_valid  <= 1'b1;
            pc        <= pc_inc;
            pc_next_r <= pc_inc;
        end else if (consume) begin
            ir_valid <= 1'b0;
        end
    end

    // The request is masked by reset so memory never sees a read while the
    // block is being reset, even though the state register still shows a
    // requesting state during that first reset cycle.
    assign IMEM_req  = mem_req & RESET_N;
    assign IMEM_addr = pc;

    assign IR_valid  = ir_valid;
    assign IR_opcode = ir[31:28];
    assign IR_ARn    = ir[23:20];
    assign IR_ARs    = ir[19:16];
    assign IR_ARm    = ir[15:12];
    assign IR_imm    = ir[15:0];
    assign PC_next   = pc_next_r;

    // Opcode 0xF is branch-and-link: the return address always goes to R15.
    assign mux_ARd_or_15 = (ir[31:28] == 4'hF) ? 4'hF : ir[27:24];

    // Opcodes 0xA-0xE never write a register.
    assign writes_reg = (ir[31:28] <= 4'h9) || (ir[31:28] == 4'hF);

    assign CNTRL_write_en_ARd = ir_valid & ~stall & ~branch_taken & writes_reg;

endmodule
